// File: rtl/demux_1_to_2_reg_pkg.sv
// Shared steering constants and slot state encoding for the 1-to-2 demux
// and the other lane-steering blocks of the processor.
package demux_1_to_2_reg_pkg;

    // Lane identifiers as carried on a select bit.
    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // Default payload and transfer-counter widths.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Occupancy of a one-entry output slot.
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : demux_1_to_2_reg_pkg

// File: rtl/demux_slot.sv
// One-entry output register with valid/ready handshake, EMPTY/FULL FSM and
// a wrap-around count of accepted loads. The parent only asserts load when
// space is high, so a load never overwrites stalled data.
module demux_slot
    import demux_1_to_2_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             space
);

    slot_state_e      state_reg;
    slot_state_e      state_next;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] cnt_reg;

    // State register: slot occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SLOT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: fill on load, empty only on a drain without a refill.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SLOT_EMPTY: if (load) state_next = SLOT_FULL;
            SLOT_FULL:  if (ready && !load) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    // Outputs: valid follows occupancy; space means a load can land this edge.
    always_comb begin
        valid = (state_reg == SLOT_FULL);
        space = (state_reg == SLOT_EMPTY) || ready;
    end

    // Payload and counter: capture data and count every accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            data_reg <= load_data;
            cnt_reg  <= cnt_reg + CNT_W'(1);
        end
    end

    assign data = data_reg;
    assign cnt  = cnt_reg;

endmodule : demux_slot

// File: rtl/demux_1_to_2_reg.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream to one of
// two independently stalled output slots. Only the select decode and the
// in_ready mux live here; each lane is a demux_slot.
module demux_1_to_2_reg
    import demux_1_to_2_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [1:0]       lane_ready;
    logic [1:0]       lane_space;
    logic [1:0]       lane_load;
    logic [1:0]       lane_valid;
    logic [WIDTH-1:0] lane_data [2];
    logic [CNT_W-1:0] lane_cnt  [2];

    assign lane_ready = {out1_ready, out0_ready};

    // Input acceptance depends only on the selected lane, so a stalled lane
    // never blocks traffic headed to the other one.
    always_comb begin
        in_ready = (in_sel == LANE1) ? lane_space[1] : lane_space[0];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_load[gi] = in_valid && in_ready && (in_sel == 1'(gi));

            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (lane_load[gi]),
                .load_data (in_data),
                .ready     (lane_ready[gi]),
                .valid     (lane_valid[gi]),
                .data      (lane_data[gi]),
                .cnt       (lane_cnt[gi]),
                .space     (lane_space[gi])
            );
        end
    endgenerate

    assign out0_valid = lane_valid[0];
    assign out0_data  = lane_data[0];
    assign cnt0       = lane_cnt[0];
    assign out1_valid = lane_valid[1];
    assign out1_data  = lane_data[1];
    assign cnt1       = lane_cnt[1];

endmodule : demux_1_to_2_reg
